// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sevenseg_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } scan_state_t;

   // Width needed to count 0..max(div,gap)-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned div, input int unsigned gap);
      int unsigned m;
      m = (div > gap) ? div : gap;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_sevensegdec.sv
// Hex nibble to active-low seven-segment glyph, Y[0]=A .. Y[6]=G.
module sevensegdec (
   input  logic [3:0] I,
   output logic [0:6] Y
);

   always_comb begin
      Y = 7'b1111111;
      case (I)
         4'h0: Y = 7'b0000001;
         4'h1: Y = 7'b1001111;
         4'h2: Y = 7'b0010010;
         4'h3: Y = 7'b0000110;
         4'h4: Y = 7'b1001100;
         4'h5: Y = 7'b0100100;
         4'h6: Y = 7'b0100000;
         4'h7: Y = 7'b0001111;
         4'h8: Y = 7'b0000000;
         4'h9: Y = 7'b0000100;
         4'hA: Y = 7'b0001000;
         4'hB: Y = 7'b1100000;
         4'hC: Y = 7'b0110001;
         4'hD: Y = 7'b1000010;
         4'hE: Y = 7'b0110000;
         4'hF: Y = 7'b0111000;
         default: Y = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed common-anode scan controller with double-buffered display data,
// inter-digit blanking gap and optional leading-zero blanking.
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned DIV    = 4,
   parameter int unsigned GAP    = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  WE,
   input  logic [4*DIGITS-1:0]   DATA_IN,
   input  logic [DIGITS-1:0]     DP_IN,
   input  logic                  LZB,
   output logic [DIGITS-1:0]     AN,
   output logic [0:6]            SEG,
   output logic                  DP,
   output logic                  FRAME,
   output logic                  PEND
);

   localparam int unsigned CW = cnt_width(DIV, GAP);
   localparam int unsigned DW = $clog2(DIGITS);
   localparam int unsigned BW = 5 * DIGITS;

   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
   localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

   scan_state_t       state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [DW-1:0]     digit, digit_nxt;
   logic              frame_evt;

   // Buffer layout: {nibbles, dp bits}.
   logic [BW-1:0]     active, act_nxt;
   logic [BW-1:0]     shadow, shd_nxt;
   logic              pend_nxt;
   logic [BW-1:0]     wr_word;

   logic [3:0]        nibble;
   logic              dp_bit;
   logic              upper_zero;
   logic              lit;
   logic [0:6]        dec_y;
   logic [DIGITS-1:0] an_nxt;
   logic [0:6]        seg_nxt;
   logic              dp_nxt;

   assign wr_word = {DATA_IN, DP_IN};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         digit  <= '0;
         active <= '0;
         shadow <= '0;
         PEND   <= 1'b0;
         AN     <= '1;
         SEG    <= SEG_OFF;
         DP     <= 1'b1;
         FRAME  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         digit  <= digit_nxt;
         active <= act_nxt;
         shadow <= shd_nxt;
         PEND   <= pend_nxt;
         AN     <= an_nxt;
         SEG    <= seg_nxt;
         DP     <= dp_nxt;
         FRAME  <= frame_evt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      digit_nxt = digit;
      frame_evt = 1'b0;
      if (!EN) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
         digit_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_SHOW;
               cnt_nxt   = '0;
               digit_nxt = '0;
            end
            ST_SHOW: begin
               if (cnt == DIV_LAST) begin
                  state_nxt = ST_GAP;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  state_nxt = ST_SHOW;
                  cnt_nxt   = '0;
                  if (digit == DIG_LAST) begin
                     digit_nxt = '0;
                     frame_evt = 1'b1;
                  end else begin
                     digit_nxt = digit + 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               digit_nxt = '0;
            end
         endcase
      end

      act_nxt  = active;
      shd_nxt  = shadow;
      pend_nxt = PEND;
      if (frame_evt) begin
         act_nxt  = WE ? wr_word : (PEND ? shadow : active);
         pend_nxt = 1'b0;
      end else if (WE) begin
         if (state == ST_IDLE) begin
            act_nxt = wr_word;
         end else begin
            shd_nxt  = wr_word;
            pend_nxt = 1'b1;
         end
      end
   end

   // Outputs are decoded from next-cycle state and buffer so the pins are
   // registered yet switch on the same edge as the transition.
   always_comb begin
      nibble     = act_nxt[DIGITS + 4*digit_nxt +: 4];
      dp_bit     = act_nxt[digit_nxt];
      upper_zero = 1'b1;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         if (j >= 32'(digit_nxt) && act_nxt[DIGITS + 4*j +: 4] != 4'h0) begin
            upper_zero = 1'b0;
         end
      end
      lit = (state_nxt == ST_SHOW) &&
            !(LZB && (digit_nxt != '0) && upper_zero && !dp_bit);
      an_nxt = '1;
      if (lit) begin
         an_nxt[digit_nxt] = 1'b0;
      end
      seg_nxt = lit ? dec_y : SEG_OFF;
      dp_nxt  = lit ? ~dp_bit : 1'b1;
   end

   sevensegdec u_dec (
      .I (nibble),
      .Y (dec_y)
   );

endmodule
